adder8_rr_scheduler: RTL and testbench

Shares one registered 8-bit adder datapath (a + b + cin -> sum, cout) between NREQ requesters. Selection is round-robin.
- Each requester presents operands with a valid/ready handshake.
- One operation is in flight at a time.
- The result is returned on a single response channel with valid/ready backpressure, tagged with the requester ID.
- The block sits between the per-client logic and the shared adder in the arithmetic tile, and keeps a saturating count of carry-out (overflow) events.

---
 rtl/adder8_rr_scheduler.sv | 131 +++++++++++++
 tb/tb_adder8_rr_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder8_rr_scheduler.sv
// rtl/adder8_rr_scheduler.sv - round-robin shared registered adder with tagged response channel
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake (req_ready one-hot or zero, combinational)
//   req_a, req_b         per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin              per-requester carry-in
//   rsp_valid/rsp_ready  response handshake
//   rsp_id, rsp_sum,     owner, sum and carry-out of the response
//   rsp_cout
//   busy                 an operation is in EXEC or RESP
//   ovf_count            saturating count of accepted responses with carry-out set
module adder8_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy,
    output logic [7:0]            ovf_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   idx;
    logic             found;
    logic             can_grant;
    logic             grant;
    logic             accept;
    logic [IDW-1:0]   op_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [WIDTH:0]   add_res;

    assign can_grant = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept    = (state == RESP) && rsp_ready;
    assign grant     = found && can_grant;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    assign add_res = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};

    // Search starts one past the last winner; the IDW-bit index wraps on its
    // own because NREQ is a power of two. k == NREQ lands back on rr_ptr.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = rr_ptr + IDW'(k);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Grants are suppressed while reset is held so no requester sees a
    // handshake that the registers cannot capture.
    always_comb begin
        req_ready = '0;
        if (grant && !rst) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (accept) state_nxt = grant ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= IDW'(NREQ - 1);
            op_id     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            ovf_count <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                op_id  <= winner;
                op_a   <= req_a[int'(winner)*WIDTH +: WIDTH];
                op_b   <= req_b[int'(winner)*WIDTH +: WIDTH];
                op_cin <= req_cin[winner];
                rr_ptr <= winner;
            end
            // The response register is only written at the end of EXEC, so a
            // grant in the same cycle as an accept cannot disturb the accepted data.
            if (state == EXEC) begin
                rsp_id   <= op_id;
                rsp_sum  <= add_res[WIDTH-1:0];
                rsp_cout <= add_res[WIDTH];
            end
            if (accept && rsp_cout && (ovf_count != 8'hFF)) begin
                ovf_count <= ovf_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_adder8_rr_scheduler.sv
// tb/tb_adder8_rr_scheduler.sv - scoreboard bench for adder8_rr_scheduler
module tb_adder8_rr_scheduler;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_cin = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_cout;
    logic        busy;
    logic [7:0]  ovf_count;

    adder8_rr_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int sum;
        int cout;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model: last granted requester, whether an operation is
    // outstanding, and the cycle in which it was granted.
    int   m_last = NREQ - 1;
    bit   m_out  = 0;
    int   m_gcyc = 0;
    int   cyc    = 0;
    int   m_ovf  = 0;

    int   ta  [NREQ];
    int   tb_ [NREQ];
    bit   tci [NREQ];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational grant and status,
    // then advance the model across the rising edge.
    task automatic step(input logic [3:0] v, input bit rdy);
        int  win;
        bit  resp_shown;
        bit  cg;
        int  s;
        exp_t e;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rdy;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*8 +: 8] = ta[i][7:0];
            req_b[i*8 +: 8] = tb_[i][7:0];
            req_cin[i]      = tci[i];
        end
        #2;
        win = -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (win < 0 && v[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
        end
        resp_shown = m_out && (cyc >= m_gcyc + 2);
        cg = !m_out || (resp_shown && rdy);
        chk("req_ready", int'(req_ready), (win >= 0 && cg) ? (1 << win) : 0);
        chk("rsp_valid", int'(rsp_valid), int'(resp_shown));
        chk("busy", int'(busy), int'(m_out));
        @(posedge clk);
        if (resp_shown && rdy) m_out = 0;
        if (win >= 0 && cg) begin
            s = ta[win] + tb_[win] + int'(tci[win]);
            e.id = win;
            e.sum = s % 256;
            e.cout = (s > 255) ? 1 : 0;
            q.push_back(e);
            m_out  = 1;
            m_gcyc = cyc;
            m_last = win;
        end
        cyc++;
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'hF;
        #2;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(ovf_count), 0);
        repeat (ncyc) @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        m_last    = NREQ - 1;
        m_out     = 0;
    endtask

    task automatic set_op(input int id, input int a, input int b, input bit ci);
        ta[id]  = a;
        tb_[id] = b;
        tci[id] = ci;
    endtask

    task automatic single(input int id, input int a, input int b, input bit ci);
        set_op(id, a, b, ci);
        step(4'(1 << id), 1'b1);
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);
    endtask

    // Monitor: compares whatever the DUT presents against the head of the
    // scoreboard; stability under backpressure follows from repeated checks.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                q.delete();
                m_ovf = 0;
            end else begin
                chk("ovf_count", int'(ovf_count), m_ovf);
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (id=%0d)", rsp_id);
                    end else begin
                        chk("rsp_id", int'(rsp_id), q[0].id);
                        chk("rsp_sum", int'(rsp_sum), q[0].sum);
                        chk("rsp_cout", int'(rsp_cout), q[0].cout);
                        if (rsp_ready) begin
                            e = q.pop_front();
                            if (e.cout == 1 && m_ovf < 255) m_ovf++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int waitc;
        for (int i = 0; i < NREQ; i++) set_op(i, 0, 0, 1'b0);

        // Reset with everything requesting; first grant goes to requester 0.
        do_reset(3);
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10, 1'b0);
        step(4'hF, 1'b1);
        chk("first_grant_req0", m_last, 0);
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);

        // Single operation, then overflow cases.
        single(1, 12, 7, 1'b0);
        step(4'h0, 1'b1);
        single(0, 255, 1, 1'b0);
        single(0, 240, 15, 1'b1);
        single(0, 170, 85, 1'b0);
        single(2, 255, 255, 1'b1);
        step(4'h0, 1'b1);

        // Round-robin with all requesters held.
        for (int i = 0; i < NREQ; i++) set_op(i, 30 * i, 100 + i, i[0]);
        repeat (12) step(4'hF, 1'b1);

        // Backpressure: hold a response for 5 cycles, then accept + regrant.
        single(3, 200, 100, 1'b0);
        set_op(3, 50, 60, 1'b1);
        step(4'h8, 1'b1);
        step(4'h9, 1'b0);
        repeat (5) step(4'h9, 1'b0);
        step(4'h9, 1'b1);
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);

        // Reset during EXEC of requester 2; arbitration restarts at 0.
        set_op(2, 9, 9, 1'b0);
        set_op(3, 4, 4, 1'b0);
        step(4'h4, 1'b1);
        do_reset(1);
        step(4'hC, 1'b1);
        chk("restart_grant_req2", m_last, 2);
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom));
            step(4'($urandom), ($urandom_range(0, 9) < 7));
        end

        // Saturate the overflow counter.
        for (int i = 0; i < NREQ; i++) set_op(i, 255, 1, 1'b0);
        repeat (600) step(4'h1, 1'b1);

        // Drain with a bounded wait.
        waitc = 0;
        while (q.size() != 0 && waitc < 20) begin
            step(4'h0, 1'b1);
            waitc++;
        end
        chk("drain_queue_empty", q.size(), 0);
        step(4'h0, 1'b1);
        chk("ovf_saturated", int'(ovf_count), 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
